// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gol_pkg
// Purpose  : Shared constants and types for the Game-of-Life frame readout.
//            Holds the default grid geometry / word packing and the readout
//            FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gol_pkg;

  // Default grid geometry and output word packing.
  localparam int c_GRID_W = 16;
  localparam int c_GRID_H = 16;
  localparam int c_PACK   = 8;

  // Readout FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } gol_state_t;

endpackage : gol_pkg
`default_nettype wire

// File: rtl/gol_popcount.sv
`default_nettype none
// ============================================================================
// Module   : gol_popcount
// Purpose  : Combinational population count of one packed output word.
// Ports    : i_data  [PACK-1:0]            - packed cell states
//            o_count [clog2(PACK+1)-1:0]   - number of set bits in i_data
// Revision : 1.0 - initial release
// ============================================================================
module gol_popcount
  import gol_pkg::*;
#(
  parameter int PACK = c_PACK
) (
  input  logic [PACK-1:0]              i_data,
  output logic [$clog2(PACK+1)-1:0]    o_count
);

  localparam int c_CNT_W = $clog2(PACK + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < PACK; i++) begin
      o_count = o_count + c_CNT_W'(i_data[i]);
    end
  end

endmodule : gol_popcount
`default_nettype wire

// File: rtl/gol_readout.sv
`default_nettype none
// ============================================================================
// Module   : gol_readout
// Purpose  : Captures a snapshot of the Game-of-Life grid on request and
//            streams it out row-major as PACK-cell words over a valid/ready
//            handshake, with frame/row markers and a live-cell total.
// Ports    : CLK         - clock, rising edge
//            reset_n     - asynchronous active-low reset
//            grid_state  - live state of all cells, bit r*GRID_W+c
//            start       - request to capture and stream one frame
//            busy        - frame is being streamed
//            out_data    - PACK cells, bit k = column word*PACK+k
//            out_valid   - out_data and markers valid
//            out_ready   - consumer accepts the current word
//            out_sof     - first word of frame
//            out_eol     - last word of a row
//            out_eof     - last word of frame
//            live_count  - live cells in the last completed frame
//            frame_done  - one-cycle pulse after the final handshake
// Revision : 1.0 - initial release
// ============================================================================
module gol_readout
  import gol_pkg::*;
#(
  parameter int GRID_W = c_GRID_W,
  parameter int GRID_H = c_GRID_H,
  parameter int PACK   = c_PACK
) (
  input  logic                                  CLK,
  input  logic                                  reset_n,
  input  logic [GRID_W*GRID_H-1:0]              grid_state,
  input  logic                                  start,
  output logic                                  busy,
  output logic [PACK-1:0]                       out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_sof,
  output logic                                  out_eol,
  output logic                                  out_eof,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0]    live_count,
  output logic                                  frame_done
);

  // GRID_W must be a whole multiple of PACK so every row splits into
  // complete words.
  localparam int c_CELLS = GRID_W * GRID_H;
  localparam int c_WPR   = GRID_W / PACK;
  localparam int c_COL_W = (c_WPR  > 1) ? $clog2(c_WPR)  : 1;
  localparam int c_ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int c_IDX_W = (c_CELLS > 1) ? $clog2(c_CELLS) : 1;
  localparam int c_SUM_W = $clog2(c_CELLS + 1);
  localparam int c_CNT_W = $clog2(PACK + 1);

  gol_state_t               r_state;
  gol_state_t               w_state_nxt;

  logic [c_CELLS-1:0]       r_snap;
  logic [c_COL_W-1:0]       r_col;
  logic [c_ROW_W-1:0]       r_row;
  logic [c_SUM_W-1:0]       r_sum;
  logic [c_SUM_W-1:0]       r_live_count;

  logic                     w_streaming;
  logic                     w_handshake;
  logic                     w_last_col;
  logic                     w_last_row;
  logic                     w_capture;
  logic                     w_load_total;
  logic [c_IDX_W-1:0]       w_base;
  logic [PACK-1:0]          w_word;
  logic [c_CNT_W-1:0]       w_pop;

  // --------------------------------------------------------------------------
  // Word addressing: all outputs derive from registered indices and the
  // snapshot, so they are naturally stable while the consumer stalls.
  // --------------------------------------------------------------------------
  assign w_streaming = (r_state == STREAM);
  assign w_handshake = w_streaming & out_ready;
  assign w_last_col  = (r_col == c_COL_W'(c_WPR - 1));
  assign w_last_row  = (r_row == c_ROW_W'(GRID_H - 1));
  assign w_base      = c_IDX_W'(int'(r_row) * GRID_W + int'(r_col) * PACK);
  assign w_word      = r_snap[w_base +: PACK];

  assign out_data    = w_streaming ? w_word : '0;
  assign out_sof     = w_streaming & (r_col == '0) & (r_row == '0);
  assign out_eol     = w_streaming & w_last_col;
  assign out_eof     = w_streaming & w_last_col & w_last_row;
  assign live_count  = r_live_count;

  gol_popcount #(
    .PACK (PACK)
  ) u_popcount (
    .i_data  (w_word),
    .o_count (w_pop)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b0;
    out_valid    = 1'b0;
    frame_done   = 1'b0;
    w_capture    = 1'b0;
    w_load_total = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_handshake && w_last_col && w_last_row) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        // start is deliberately not examined here.
        frame_done   = 1'b1;
        w_load_total = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: snapshot, word indices, running count, published total.
  // The running count is sized for a full grid, so it cannot wrap.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_snap       <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_sum        <= '0;
      r_live_count <= '0;
    end else begin
      if (w_capture) begin
        r_snap <= grid_state;
        r_col  <= '0;
        r_row  <= '0;
        r_sum  <= '0;
      end else if (w_handshake) begin
        r_sum <= r_sum + c_SUM_W'(w_pop);
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_load_total) begin
        r_live_count <= r_sum;
      end
    end
  end

endmodule : gol_readout
`default_nettype wire

// File: doc/gol_readout.md
GOL_READOUT -- requirements
Module: gol_readout

Interface
REQ-001 Parameter GRID_W, default 16: number of grid columns.
REQ-002 Parameter GRID_H, default 16: number of grid rows.
REQ-003 Parameter PACK, default 8: cells per output word; GRID_W SHALL be an integer multiple of PACK.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 grid_state  input  GRID_W*GRID_H  live state of every cell; bit r*GRID_W+c is row r, column c.
REQ-007 start  input  1  one-cycle request to capture and stream one frame.
REQ-008 busy  output  1  high from the capture cycle until the final word handshake.
REQ-009 out_data  output  PACK  cell states; bit k is column (word_index*PACK + k).
REQ-010 out_valid  output  1  out_data and markers valid.
REQ-011 out_ready  input  1  consumer accepts the word when high together with out_valid.
REQ-012 out_sof / out_eol / out_eof  output  1 each  first word of frame / last word of row / last word of frame.
REQ-013 live_count  output  clog2(GRID_W*GRID_H+1)  live cells in the last completed frame.
REQ-014 frame_done  output  1  one-cycle pulse on the cycle after the final handshake.

Function
REQ-015 FSM states SHALL be IDLE, STREAM and FINISH.
REQ-016 IDLE: on start=1, grid_state SHALL be copied into a snapshot register, and the FSM SHALL move to STREAM with busy=1 on the next cycle.
REQ-017 start SHALL be ignored in STREAM and FINISH.
REQ-018 Later changes on grid_state SHALL NOT affect the frame being streamed.
REQ-019 STREAM: out_valid SHALL assert on the first STREAM cycle, which is one cycle after start.
REQ-020 Words SHALL be emitted row-major, row 0 first, columns ascending, GRID_W/PACK words per row.
REQ-021 While out_valid=1 and out_ready=0, out_data and all markers SHALL hold stable.
REQ-022 The word/row index SHALL advance only on an out_valid & out_ready handshake.
REQ-023 Back-to-back handshakes SHALL sustain one word per cycle.
REQ-024 out_sof SHALL be high only on word 0 of row 0.
REQ-025 out_eol SHALL be high on the last word of each row.
REQ-026 out_eof SHALL be high only on the last word of the last row.
REQ-027 Markers SHALL be 0 whenever out_valid=0.
REQ-028 A running count SHALL add the popcount of each handshaken word; the addition SHALL never wrap.
REQ-029 On the final handshake (out_eof), the FSM SHALL enter FINISH.
REQ-030 FINISH: live_count SHALL be loaded with the final sum, frame_done SHALL pulse for one cycle, busy and out_valid SHALL be 0, and the FSM SHALL return to IDLE.
REQ-031 live_count SHALL hold its value until the next FINISH.
REQ-032 A start arriving in the FINISH cycle SHALL be ignored.
REQ-033 A start arriving in the cycle after FINISH SHALL be accepted.
REQ-034 The running count SHALL clear on each accepted start.

Reset
REQ-035 reset_n=0 SHALL asynchronously force the FSM to IDLE, whether idle or mid-frame.
REQ-036 Reset SHALL clear busy, out_valid, out_sof, out_eol, out_eof, frame_done, out_data, live_count, the running count, the indices and the snapshot.
REQ-037 After reset_n rises, the first rising edge with start=1 SHALL begin a fresh frame.
REQ-038 A frame interrupted by reset SHALL NOT produce frame_done.

Structure
REQ-039 Shared package gol_pkg SHALL hold the default GRID_W, GRID_H and PACK constants and the FSM state enum typedef.
REQ-040 One sub-module gol_popcount (PACK-bit input, clog2(PACK+1)-bit combinational count) SHALL compute per-word live cells.

Verification
REQ-041 Reset, all-zero grid, start, out_ready=1 -> 32 words all 0x00; sof on word 0; eol on words 1,3,...,31; eof on word 31; live_count=0; frame_done exactly once.
REQ-042 Glider at (r1,c2), (r2,c3), (r3,c1..3), out_ready=1 -> word2=0x04, word4=0x08, word6=0x0E, all others 0; live_count=5.
REQ-043 All-ones grid with out_ready toggled 1,0,0,1,...; grid_state cleared after start -> every word 0xFF, data stable during stalls, live_count=256, exactly 32 handshakes.
REQ-044 start pulsed at words 5 and 20 and in the FINISH cycle -> exactly one frame, one frame_done; start the following cycle -> second frame begins.
REQ-045 reset_n low after word 10 with out_ready=0 -> out_valid=0 and busy=0 immediately, no frame_done; a subsequent start streams from word 0 with sof=1.
